// File: rtl/simple_processor_pkg.sv
// Shared types and constants for the simple_processor ALU shift path.
// Holds the shift opcode encoding, the right-shift FSM state encoding and
// the default operand / shift-amount widths.
package simple_processor_pkg;

  localparam int SP_DATA_WIDTH  = 32;
  localparam int SP_SHIFT_WIDTH = 5;

  // Encoding 2'b11 is reserved and executes as a logical shift.
  typedef enum logic [1:0] {
    SHIFT_SRL = 2'b00,
    SHIFT_SRA = 2'b01,
    SHIFT_ROR = 2'b10
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } shift_rt_state_e;

endpackage

// File: rtl/alu_shift_right_step.sv
// Combinational single-bit right step: drops data_i[0] and inserts fill_i at the MSB.
module alu_shift_right_step
  import simple_processor_pkg::*;
#(
  parameter int DATA_WIDTH = SP_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  fill_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  // Bit 0 is the bit being shifted out; the caller decides whether it feeds back as fill.
  logic unused_lsb;
  assign unused_lsb = data_i[0];

  assign data_o = {fill_i, data_i[DATA_WIDTH-1:1]};

endmodule

// File: rtl/alu_shift_right_seq.sv
// Multi-cycle right-shift unit (SRL / SRA / optional ROR), one bit per cycle.
// Request is accepted only in IDLE; the result is held with rsp_valid_o until
// the consumer takes it. Optional rotate support is enabled by defining
// ALU_SHIFT_ROTATE_EN; without it SHIFT_ROR executes as a logical shift.
module alu_shift_right_seq
  import simple_processor_pkg::*;
#(
  parameter int DATA_WIDTH  = SP_DATA_WIDTH,
  parameter int SHIFT_WIDTH = SP_SHIFT_WIDTH
) (
  input  logic                   clk,
  input  logic                   arst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [DATA_WIDTH-1:0]  rs1_data_i,
  input  logic [SHIFT_WIDTH-1:0] shamt_i,
  input  shift_op_e              op_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [DATA_WIDTH-1:0]  result_o,
  output logic                   busy_o
);

  shift_rt_state_e        state_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic [DATA_WIDTH-1:0]  data_d;
  logic [SHIFT_WIDTH-1:0] count_q;
  logic [SHIFT_WIDTH-1:0] count_d;
  logic                   sign_q;
  shift_op_e              op_q;
  logic                   rsp_valid_q;
  logic                   busy_q;
  logic                   fill;

  // Select the bit entering at the MSB; reserved and disabled encodings fall back to zero fill.
  always_comb begin
    fill = 1'b0;
    case (op_q)
      SHIFT_SRA: fill = sign_q;
`ifdef ALU_SHIFT_ROTATE_EN
      SHIFT_ROR: fill = data_q[0];
`endif
      default:   fill = 1'b0;
    endcase
  end

  alu_shift_right_step #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_step (
    .data_i (data_q),
    .fill_i (fill),
    .data_o (data_d)
  );

  // Remaining-shift counter next value.
  always_comb begin
    count_d = count_q - SHIFT_WIDTH'(1);
  end

  // Control FSM with operand, counter and response registers; reset discards any in-flight op.
  always_ff @(posedge clk or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= IDLE;
      data_q      <= '0;
      count_q     <= '0;
      sign_q      <= 1'b0;
      op_q        <= SHIFT_SRL;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            data_q  <= rs1_data_i;
            sign_q  <= rs1_data_i[DATA_WIDTH-1];
            op_q    <= op_i;
            count_q <= shamt_i;
            busy_q  <= 1'b1;
            if (shamt_i != '0) begin
              state_q <= SHIFT;
            end else begin
              state_q     <= DONE;
              rsp_valid_q <= 1'b1;
            end
          end
        end
        SHIFT: begin
          data_q  <= data_d;
          count_q <= count_d;
          if (count_q == SHIFT_WIDTH'(1)) begin
            state_q     <= DONE;
            rsp_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready_i) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // Ready is held low while reset is asserted so nothing is offered during reset.
  assign req_ready_o = (state_q == IDLE) && !arst_i;
  assign rsp_valid_o = rsp_valid_q;
  assign busy_o      = busy_q;
  assign result_o    = data_q;

endmodule

// File: tb/tb_alu_shift_right_seq.sv
// Self-checking bench for alu_shift_right_seq with a behavioural shift model.
module tb_alu_shift_right_seq;
  import simple_processor_pkg::*;

  localparam int DW = SP_DATA_WIDTH;
  localparam int SW = SP_SHIFT_WIDTH;

  logic          clk = 1'b0;
  logic          arst_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [DW-1:0] rs1_data_i;
  logic [SW-1:0] shamt_i;
  shift_op_e     op_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [DW-1:0] result_o;
  logic          busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  alu_shift_right_seq dut (
    .clk         (clk),
    .arst_i      (arst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .rs1_data_i  (rs1_data_i),
    .shamt_i     (shamt_i),
    .op_i        (op_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .result_o    (result_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  // Reference: whole-word shift arithmetic.
  function automatic logic [DW-1:0] ref_shift(input logic [1:0] op, input logic [DW-1:0] a, input int sh);
    logic signed [DW-1:0] s;
    s = a;
    case (op)
      2'b01: ref_shift = s >>> sh;
`ifdef ALU_SHIFT_ROTATE_EN
      2'b10: ref_shift = (sh == 0) ? a : ((a >> sh) | (a << (DW - sh)));
`endif
      default: ref_shift = a >> sh;
    endcase
  endfunction

  // Drives one request and collects observations; comparisons are made by the callers.
  task automatic run_op(input logic [1:0] op_bits, input logic [DW-1:0] a, input int sh,
                        input int hold, output logic [DW-1:0] res, output int lat,
                        output bit busy_ok, output bit stable_ok, output bit idle_ok);
    @(negedge clk);
    busy_ok   = 1'b1;
    stable_ok = 1'b1;
    idle_ok   = 1'b0;
    req_valid_i = 1'b1;
    rs1_data_i  = a;
    shamt_i     = SW'(sh);
    op_i        = shift_op_e'(op_bits);
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    rs1_data_i  = $urandom;
    shamt_i     = SW'($urandom);
    op_i        = shift_op_e'(2'($urandom));
    lat = 1;
    while (!rsp_valid_o && lat < 100) begin
      if (req_ready_o || !busy_o) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    res = result_o;
    if (req_ready_o || !busy_o) busy_ok = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (result_o !== res || rsp_valid_o !== 1'b1 || req_ready_o !== 1'b0) stable_ok = 1'b0;
    end
    rsp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready_i = 1'b0;
    idle_ok = (rsp_valid_o === 1'b0) && (busy_o === 1'b0) && (req_ready_o === 1'b1);
  endtask

  task automatic test_reset();
    arst_i = 1'b1;
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b0;
    rs1_data_i = '0;
    shamt_i = '0;
    op_i = SHIFT_SRL;
    repeat (3) @(negedge clk);
    n_checks++;
    if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid_o); end
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_o); end
    n_checks++;
    if (result_o !== '0) begin n_fail++; $display("FAIL reset_result got %h want 0", result_o); end
    arst_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", req_ready_o); end
  endtask

  task automatic test_sra_basic();
    logic [DW-1:0] r; int l; bit b, s, i;
    run_op(2'b01, 32'h8000_0000, 4, 0, r, l, b, s, i);
    n_checks++;
    if (r !== 32'hF800_0000) begin n_fail++; $display("FAIL sra_basic_result got %h want f8000000", r); end
    n_checks++;
    if (l !== 5) begin n_fail++; $display("FAIL sra_basic_latency got %0d want 5", l); end
    n_checks++;
    if (!b) begin n_fail++; $display("FAIL sra_basic_busy got 0 want 1"); end
  endtask

  task automatic test_srl_max();
    logic [DW-1:0] r; int l; bit b, s, i;
    run_op(2'b00, 32'h8000_0000, 31, 0, r, l, b, s, i);
    n_checks++;
    if (r !== 32'h0000_0001) begin n_fail++; $display("FAIL srl_max_result got %h want 00000001", r); end
    n_checks++;
    if (l !== 32) begin n_fail++; $display("FAIL srl_max_latency got %0d want 32", l); end
    n_checks++;
    if (!b) begin n_fail++; $display("FAIL srl_max_ready_low got 0 want 1"); end
    n_checks++;
    if (!i) begin n_fail++; $display("FAIL srl_max_idle got 0 want 1"); end
  endtask

  task automatic test_shamt_zero();
    logic [DW-1:0] r; int l; bit b, s, i;
    run_op(2'b00, 32'h1234_5678, 0, 0, r, l, b, s, i);
    n_checks++;
    if (r !== 32'h1234_5678) begin n_fail++; $display("FAIL zero_result got %h want 12345678", r); end
    n_checks++;
    if (l !== 1) begin n_fail++; $display("FAIL zero_latency got %0d want 1", l); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] r; int l; bit b, s, i;
    run_op(2'b01, 32'h7FFF_FFF0, 4, 3, r, l, b, s, i);
    n_checks++;
    if (r !== 32'h07FF_FFFF) begin n_fail++; $display("FAIL bp_result got %h want 07ffffff", r); end
    n_checks++;
    if (!s) begin n_fail++; $display("FAIL bp_stable got 0 want 1"); end
    n_checks++;
    if (!i) begin n_fail++; $display("FAIL bp_idle got 0 want 1"); end
  endtask

  task automatic test_reset_mid_shift();
    logic [DW-1:0] r; int l; bit b, s, i; bit seen;
    @(negedge clk);
    req_valid_i = 1'b1;
    rs1_data_i  = 32'hDEAD_BEEF;
    shamt_i     = SW'(20);
    op_i        = SHIFT_SRA;
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    repeat (6) @(negedge clk);
    arst_i = 1'b1;
    #1;
    n_checks++;
    if ({rsp_valid_o, busy_o} !== 2'b00) begin n_fail++; $display("FAIL midrst_flags got %b want 00", {rsp_valid_o, busy_o}); end
    n_checks++;
    if (result_o !== '0) begin n_fail++; $display("FAIL midrst_result got %h want 0", result_o); end
    @(negedge clk);
    arst_i = 1'b0;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL midrst_no_rsp got 1 want 0"); end
    run_op(2'b00, 32'hF0F0_0000, 8, 0, r, l, b, s, i);
    n_checks++;
    if (r !== 32'h00F0_F000) begin n_fail++; $display("FAIL midrst_next_result got %h want 00f0f000", r); end
    n_checks++;
    if (l !== 9) begin n_fail++; $display("FAIL midrst_next_latency got %0d want 9", l); end
  endtask

  task automatic test_ror();
    logic [DW-1:0] r; int l; bit b, s, i; logic [DW-1:0] exp_v;
`ifdef ALU_SHIFT_ROTATE_EN
    exp_v = 32'h8000_0000;
`else
    exp_v = 32'h0000_0000;
`endif
    run_op(2'b10, 32'h0000_0001, 1, 0, r, l, b, s, i);
    n_checks++;
    if (r !== exp_v) begin n_fail++; $display("FAIL ror_result got %h want %h", r, exp_v); end
    n_checks++;
    if (l !== 2) begin n_fail++; $display("FAIL ror_latency got %0d want 2", l); end
  endtask

  task automatic test_reserved();
    logic [DW-1:0] r; int l; bit b, s, i;
    run_op(2'b11, 32'h8765_4321, 8, 0, r, l, b, s, i);
    n_checks++;
    if (r !== 32'h0087_6543) begin n_fail++; $display("FAIL reserved_result got %h want 00876543", r); end
  endtask

  task automatic test_random();
    logic [DW-1:0] r; int l; bit b, s, i;
    logic [1:0] op; logic [DW-1:0] a; int sh; int hold; logic [DW-1:0] exp_v;
    for (int k = 0; k < 40; k++) begin
      op   = 2'($urandom);
      a    = $urandom;
      sh   = $urandom_range(0, 31);
      hold = $urandom_range(0, 2);
      exp_v = ref_shift(op, a, sh);
      run_op(op, a, sh, hold, r, l, b, s, i);
      n_checks++;
      if (r !== exp_v) begin n_fail++; $display("FAIL rand_result op=%0d a=%h sh=%0d got %h want %h", op, a, sh, r, exp_v); end
      n_checks++;
      if (l !== sh + 1) begin n_fail++; $display("FAIL rand_latency sh=%0d got %0d want %0d", sh, l, sh + 1); end
      n_checks++;
      if (!(b && s && i)) begin n_fail++; $display("FAIL rand_handshake busy=%b stable=%b idle=%b want 111", b, s, i); end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] r; int l; bit b, s, i;
    run_op(2'b01, 32'hC000_0000, 2, 0, r, l, b, s, i);
    n_checks++;
    if (!i) begin n_fail++; $display("FAIL b2b_first_idle got 0 want 1"); end
    run_op(2'b00, 32'hC000_0000, 2, 0, r, l, b, s, i);
    n_checks++;
    if (r !== 32'h3000_0000) begin n_fail++; $display("FAIL b2b_second_result got %h want 30000000", r); end
    n_checks++;
    if (l !== 3) begin n_fail++; $display("FAIL b2b_second_latency got %0d want 3", l); end
  endtask

  initial begin
    test_reset();
    test_sra_basic();
    test_srl_max();
    test_shamt_zero();
    test_backpressure();
    test_reset_mid_shift();
    test_ror();
    test_reserved();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
